// File: rtl/triumph_wb_ctrl.sv
// triumph_wb_ctrl: writeback controller with register scoreboard, ALU result FIFO and LSU-priority arbiter
module triumph_wb_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rs1_i,
   input  logic [4:0]  issue_rs2_i,
   input  logic [4:0]  issue_rd_i,
   output logic        issue_stall_o,
   input  logic        alu_valid_i,
   input  logic [4:0]  alu_rd_i,
   input  logic [31:0] alu_data_i,
   output logic        alu_ready_o,
   input  logic        lsu_valid_i,
   input  logic [4:0]  lsu_rd_i,
   input  logic [31:0] lsu_data_i,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic [31:0] busy_o,
   output logic        err_o
);
   logic [31:0] busy_q, busy_d;
   logic [4:0]  fifo_rd_q [2];
   logic [31:0] fifo_data_q [2];
   logic        wp_q, rp_q;
   logic [1:0]  cnt_q, cnt_d;
   logic        we_q, err_q;
   logic [4:0]  waddr_q;
   logic [31:0] wdata_q;
   logic        push, bypass, sel_alu, push_mem, pop_mem, commit;
   logic [4:0]  sel_rd;
   logic [31:0] sel_data;
   // hazard check, FIFO handshake and arbitration; an empty FIFO lets the ALU offer cut straight through
   always_comb begin
      issue_stall_o = issue_valid_i & (busy_q[issue_rs1_i] | busy_q[issue_rs2_i] | busy_q[issue_rd_i]);
      alu_ready_o   = cnt_q != 2'd2;
      push          = alu_valid_i & alu_ready_o;
      bypass        = cnt_q == 2'd0;
      sel_alu       = !lsu_valid_i & (!bypass | alu_valid_i);
      push_mem      = push & !(bypass & sel_alu);
      pop_mem       = sel_alu & !bypass;
      sel_rd        = lsu_valid_i ? lsu_rd_i : bypass ? alu_rd_i : fifo_rd_q[rp_q];
      sel_data      = lsu_valid_i ? lsu_data_i : bypass ? alu_data_i : fifo_data_q[rp_q];
      commit        = (lsu_valid_i | sel_alu) & (sel_rd != 5'd0);
      cnt_d         = cnt_q + {1'b0, push_mem} - {1'b0, pop_mem};
   end
   // scoreboard next state: commit clears, accepted issue sets, set wins on a collision
   always_comb begin
      busy_d = busy_q;
      if (we_q) busy_d[waddr_q] = 1'b0;
      if (issue_valid_i && !issue_stall_o) busy_d[issue_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
   end
   // FIFO storage, kept out of reset since occupancy alone defines validity
   always_ff @(posedge clk_i) begin
      if (!rst_i && push_mem) begin
         fifo_rd_q[wp_q]   <= alu_rd_i;
         fifo_data_q[wp_q] <= alu_data_i;
      end
   end
   // pointers, write-port register, scoreboard and sticky error
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp_q    <= 1'b0;
         rp_q    <= 1'b0;
         cnt_q   <= 2'd0;
         we_q    <= 1'b0;
         waddr_q <= 5'd0;
         wdata_q <= 32'd0;
         err_q   <= 1'b0;
         busy_q  <= 32'd0;
      end else begin
         if (push_mem) wp_q <= ~wp_q;
         if (pop_mem) rp_q <= ~rp_q;
         cnt_q <= cnt_d;
         we_q  <= commit;
         if (commit) begin
            waddr_q <= sel_rd;
            wdata_q <= sel_data;
         end
         err_q  <= err_q | (we_q & !busy_q[waddr_q]);
         busy_q <= busy_d;
      end
   end
   assign rf_we_o    = we_q;
   assign rf_waddr_o = waddr_q;
   assign rf_wdata_o = wdata_q;
   assign busy_o     = busy_q;
   assign err_o      = err_q;
endmodule

// File: tb/tb_triumph_wb_ctrl.sv
// tb_triumph_wb_ctrl: directed vector table, corner sequences and random traffic against a queue-based reference model
module tb_triumph_wb_ctrl;
   typedef struct {
      logic        rst, iv;
      logic [4:0]  rs1, rs2, rd;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adata;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldata;
      logic        e_stall, e_ready, e_we;
      logic [4:0]  e_waddr;
      logic [31:0] e_wdata, e_busy;
      logic        e_err;
   } vec_t;
   logic        clk_i = 0, rst_i, issue_valid_i, alu_valid_i, lsu_valid_i;
   logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i, alu_rd_i, lsu_rd_i;
   logic [31:0] alu_data_i, lsu_data_i;
   logic        issue_stall_o, alu_ready_o, rf_we_o, err_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o, busy_o;
   int          n_chk = 0, n_fail = 0;
   logic [31:0] m_busy;
   logic [36:0] m_q[$];
   logic        m_we, m_err, known = 0;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   vec_t        tbl[16];
   vec_t        v;
   always #5 clk_i = ~clk_i;
   triumph_wb_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .issue_valid_i(issue_valid_i), .issue_rs1_i(issue_rs1_i),
      .issue_rs2_i(issue_rs2_i), .issue_rd_i(issue_rd_i), .issue_stall_o(issue_stall_o),
      .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
      .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i), .rf_we_o(rf_we_o),
      .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .busy_o(busy_o), .err_o(err_o)
   );
   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction
   function automatic vec_t idle();
      vec_t r;
      r = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      return r;
   endfunction
   function automatic logic m_stall(vec_t x);
      return x.iv && (m_busy[x.rs1] || m_busy[x.rs2] || m_busy[x.rd]);
   endfunction
   // reference: results queue in arrival order; LSU first, else oldest queued ALU result (one accepted this cycle counts)
   function automatic void model_edge(vec_t x);
      logic [31:0] nb;
      logic        sel;
      logic [36:0] r;
      if (x.rst) begin
         m_busy = 0; m_q.delete(); m_we = 0; m_waddr = 0; m_wdata = 0; m_err = 0; known = 1;
         return;
      end
      nb = m_busy;
      if (m_we) nb[m_waddr] = 0;
      if (x.iv && !m_stall(x) && x.rd != 0) nb[x.rd] = 1;
      if (m_we && !m_busy[m_waddr]) m_err = 1;
      if (x.av && m_q.size() < 2) m_q.push_back({x.ard, x.adata});
      sel = 0; r = 0;
      if (x.lv) begin sel = 1; r = {x.lrd, x.ldata}; end
      else if (m_q.size() > 0) begin sel = 1; r = m_q.pop_front(); end
      m_we = sel && r[36:32] != 0;
      if (m_we) begin m_waddr = r[36:32]; m_wdata = r[31:0]; end
      m_busy = nb;
   endfunction
   task automatic step(input vec_t x, input bit use_exp);
      rst_i = x.rst; issue_valid_i = x.iv; issue_rs1_i = x.rs1; issue_rs2_i = x.rs2; issue_rd_i = x.rd;
      alu_valid_i = x.av; alu_rd_i = x.ard; alu_data_i = x.adata;
      lsu_valid_i = x.lv; lsu_rd_i = x.lrd; lsu_data_i = x.ldata;
      #1;
      if (!x.rst && known) begin
         check("stall", issue_stall_o, m_stall(x));
         check("ready", alu_ready_o, m_q.size() < 2);
      end
      if (use_exp && !x.rst) begin
         check("tbl_stall", issue_stall_o, x.e_stall);
         check("tbl_ready", alu_ready_o, x.e_ready);
      end
      @(posedge clk_i);
      model_edge(x);
      #1;
      check("we", rf_we_o, m_we);
      check("waddr", rf_waddr_o, m_waddr);
      check("wdata", rf_wdata_o, m_wdata);
      check("busy", busy_o, m_busy);
      check("err", err_o, m_err);
      if (use_exp) begin
         check("tbl_we", rf_we_o, x.e_we);
         check("tbl_waddr", rf_waddr_o, x.e_waddr);
         check("tbl_wdata", rf_wdata_o, x.e_wdata);
         check("tbl_busy", busy_o, x.e_busy);
         check("tbl_err", err_o, x.e_err);
      end
   endtask
   initial begin
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h20, 0};
      tbl[2]  = '{0, 1, 5, 0, 6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h20, 0};
      tbl[3]  = '{0, 1, 5, 0, 6, 1, 5, 32'hAA, 0, 0, 0, 1, 1, 1, 5, 32'hAA, 32'h20, 0};
      tbl[4]  = '{0, 1, 5, 0, 6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 32'hAA, 0, 0};
      tbl[5]  = '{0, 1, 5, 0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 32'hAA, 32'h40, 0};
      tbl[6]  = '{0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 32'hAA, 32'h48, 0};
      tbl[7]  = '{0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 32'hAA, 32'h58, 0};
      tbl[8]  = '{0, 0, 0, 0, 0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 1, 1, 4, 32'h22, 32'h58, 0};
      tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 32'h11, 32'h48, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 32'h11, 32'h40, 0};
      tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, 3, 32'h11, 32'h40, 0};
      tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 32'h11, 32'h40, 0};
      tbl[13] = '{0, 0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0, 1, 1, 7, 32'h77, 32'h40, 0};
      tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 32'h77, 32'h40, 1};
      tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 32'h77, 32'h40, 1};
      for (int i = 0; i < 16; i++) step(tbl[i], 1);
      // LSU hogs the port for three cycles while the ALU offers three results
      v = idle(); v.rst = 1; step(v, 0);
      v = idle(); v.lv = 1; v.lrd = 10; v.ldata = 32'hA0; v.av = 1; v.ard = 1; v.adata = 32'h101; step(v, 0);
      v.lrd = 11; v.ldata = 32'hA1; v.ard = 2; v.adata = 32'h102; step(v, 0);
      check("r29_full", alu_ready_o, 0);
      v.lrd = 12; v.ldata = 32'hA2; v.ard = 3; v.adata = 32'h103; step(v, 0);
      check("r29_lsu_last", rf_waddr_o, 12);
      v.lv = 0; step(v, 0);
      check("r29_first", rf_waddr_o, 1);
      step(v, 0);
      check("r29_second", rf_waddr_o, 2);
      v = idle(); step(v, 0);
      check("r29_third", {rf_we_o, rf_waddr_o, rf_wdata_o[7:0]}, {1'b1, 5'd3, 8'h03});
      step(v, 0);
      check("r29_drained", rf_we_o, 0);
      // reset with a full FIFO and a busy register
      v = idle(); v.iv = 1; v.rd = 9; step(v, 0);
      v = idle(); v.lv = 1; v.lrd = 20; v.av = 1; v.ard = 9; v.adata = 32'h99; step(v, 0);
      v.ard = 9; v.adata = 32'h98; step(v, 0);
      check("r32_full", alu_ready_o, 0);
      v = idle(); v.rst = 1; step(v, 0);
      check("r32_busy", busy_o, 0);
      check("r32_we", rf_we_o, 0);
      check("r32_ready", alu_ready_o, 1);
      v = idle();
      for (int i = 0; i < 3; i++) begin
         step(v, 0);
         check("r32_nowrite", rf_we_o, 0);
      end
      // random traffic on a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         v = idle();
         v.rst = ($urandom_range(0, 79) == 0);
         v.iv = $urandom_range(0, 1); v.rs1 = 5'($urandom_range(0, 7)); v.rs2 = 5'($urandom_range(0, 7)); v.rd = 5'($urandom_range(0, 7));
         v.av = ($urandom_range(0, 9) < 4); v.ard = 5'($urandom_range(0, 7)); v.adata = $urandom;
         v.lv = ($urandom_range(0, 9) < 3); v.lrd = 5'($urandom_range(0, 7)); v.ldata = $urandom;
         step(v, 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
